// File: rtl/jet_topn_sorter.sv
// Keeps the NJET highest-pT jets of one eta-slice event in a sorted register table,
// then drains them highest-pT first over a valid/ready handshake.
module jet_topn_sorter #(
  parameter int NJET = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [22:0] jet_in,
  input  logic        jet_in_valid,
  input  logic        event_done,
  output logic [22:0] out_jet,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic [4:0]  n_jets,
  output logic        busy,
  output logic        dropped
);

  localparam int IW = (NJET > 1) ? $clog2(NJET) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NJET - 1);

  typedef enum logic [1:0] {COLLECT, FLUSH, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   rd_idx_q, rd_idx_d;
  logic [NJET-1:0] full_q, full_d;
  logic [22:0]     slot_q [NJET];
  logic [22:0]     slot_d [NJET];
  logic [4:0]      n_jets_q, n_jets_d;
  logic            dropped_q, dropped_d;
  logic            out_valid_q, out_valid_d;
  logic            out_last_q, out_last_d;
  logic            busy_q, busy_d;
  logic [22:0]     out_jet_q, out_jet_d;

  logic [NJET-1:0] ins_here;
  logic            ins_en;
  logic            clr;

  // ins_here is monotone because the table is kept sorted with empties at the tail,
  // so the first set bit is the insertion point and every later set bit shifts down.
  always_comb begin
    for (int i = 0; i < NJET; i++) begin
      ins_here[i] = !full_q[i] || (slot_q[i][8:0] < jet_in[8:0]);
    end
  end

  always_comb begin
    state_d   = state_q;
    rd_idx_d  = rd_idx_q;
    full_d    = full_q;
    n_jets_d  = n_jets_q;
    dropped_d = dropped_q;
    ins_en    = 1'b0;
    clr       = 1'b0;
    for (int i = 0; i < NJET; i++) begin
      slot_d[i] = slot_q[i];
    end

    case (state_q)
      COLLECT: begin
        ins_en = jet_in_valid;
        if (event_done) state_d = FLUSH;
      end
      FLUSH: begin
        ins_en  = jet_in_valid;
        state_d = DRAIN;
      end
      DRAIN: begin
        if (jet_in_valid) dropped_d = 1'b1;
        if (out_valid_q && out_ready) begin
          if (rd_idx_q == LAST_IDX) begin
            state_d  = COLLECT;
            clr      = 1'b1;
            rd_idx_d = '0;
            n_jets_d = '0;
          end else begin
            rd_idx_d = rd_idx_q + IW'(1);
          end
        end
      end
      default: state_d = COLLECT;
    endcase

    if (ins_en) begin
      if (n_jets_q != 5'd31) n_jets_d = n_jets_q + 5'd1;
      if (ins_here[0]) begin
        slot_d[0] = jet_in;
        full_d[0] = 1'b1;
      end
      for (int i = 1; i < NJET; i++) begin
        if (ins_here[i]) begin
          if (!ins_here[i-1]) begin
            slot_d[i] = jet_in;
            full_d[i] = 1'b1;
          end else begin
            slot_d[i] = slot_q[i-1];
            full_d[i] = full_q[i-1];
          end
        end
      end
    end

    if (clr) full_d = '0;

    // Outputs are registered from next-state values so they line up with the state.
    out_valid_d = (state_d == DRAIN);
    out_last_d  = out_valid_d && (rd_idx_d == LAST_IDX);
    out_jet_d   = (out_valid_d && full_d[rd_idx_d]) ? slot_d[rd_idx_d] : 23'd0;
    busy_d      = (state_d != COLLECT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= COLLECT;
      rd_idx_q    <= '0;
      full_q      <= '0;
      n_jets_q    <= '0;
      dropped_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      out_jet_q   <= '0;
    end else begin
      state_q     <= state_d;
      rd_idx_q    <= rd_idx_d;
      full_q      <= full_d;
      n_jets_q    <= n_jets_d;
      dropped_q   <= dropped_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      out_jet_q   <= out_jet_d;
    end
  end

  // Slot payloads need no reset: occupancy lives in full_q.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NJET; i++) begin
      slot_q[i] <= slot_d[i];
    end
  end

  assign out_jet   = out_jet_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign n_jets    = n_jets_q;
  assign busy      = busy_q;
  assign dropped   = dropped_q;

endmodule

// File: tb/tb_jet_topn_sorter.sv
// Bench for jet_topn_sorter: directed event scenarios plus random events, compared
// against a stable-sort top-N reference model of the received jets.
module tb_jet_topn_sorter;
  localparam int NJET = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [22:0] jet_in;
  logic        jet_in_valid;
  logic        event_done;
  logic [22:0] out_jet;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic [4:0]  n_jets;
  logic        busy;
  logic        dropped;

  jet_topn_sorter #(.NJET(NJET)) dut (
    .clk(clk), .reset(reset), .jet_in(jet_in), .jet_in_valid(jet_in_valid),
    .event_done(event_done), .out_jet(out_jet), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .n_jets(n_jets), .busy(busy),
    .dropped(dropped)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [22:0] mdl_q[$];
  logic [22:0] exp_arr [NJET];
  int          exp_n;
  logic        exp_dropped = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [22:0] mk(input int pt, input int phi);
    logic [4:0] nt;
    logic [3:0] nx;
    nt = 5'($urandom);
    nx = 4'($urandom);
    return {nt, nx, 5'(phi), 9'(pt)};
  endfunction

  // Reference: stable descending sort of every accepted jet by pt, keep the first NJET.
  function automatic void build_exp();
    bit used [$];
    used = {};
    foreach (mdl_q[i]) used.push_back(1'b0);
    for (int k = 0; k < NJET; k++) begin
      int best;
      best = -1;
      foreach (mdl_q[i]) begin
        if (!used[i] && (best < 0 || mdl_q[i][8:0] > mdl_q[best][8:0])) best = i;
      end
      if (best < 0) exp_arr[k] = 23'd0;
      else begin
        exp_arr[k] = mdl_q[best];
        used[best] = 1'b1;
      end
    end
    exp_n = (mdl_q.size() > 31) ? 31 : mdl_q.size();
  endfunction

  task automatic send(input logic [22:0] j);
    @(negedge clk);
    jet_in = j;
    jet_in_valid = 1'b1;
    mdl_q.push_back(j);
    @(posedge clk);
    #1 jet_in_valid = 1'b0;
  endtask

  task automatic end_event(input bit co_jet, input bit trail, input logic [22:0] tj);
    @(negedge clk);
    event_done = 1'b1;
    if (co_jet) begin
      jet_in = mk($urandom_range(0, 511), 3);
      jet_in_valid = 1'b1;
      mdl_q.push_back(jet_in);
    end
    @(posedge clk);
    #1 event_done = 1'b0;
    jet_in_valid = 1'b0;
    if (trail) begin
      jet_in = tj;
      jet_in_valid = 1'b1;
      mdl_q.push_back(tj);
    end
    @(negedge clk);
    check("flush_valid", out_valid, 0);
    check("flush_busy", busy, 1);
    @(posedge clk);
    #1 jet_in_valid = 1'b0;
    @(negedge clk);
    check("latency_valid", out_valid, 1);
    build_exp();
  endtask

  // mode 0: ready high, 1: ready pattern 1,0,0, 2: random ready and stray event_done.
  task automatic drain(input int mode, input int drop_at, input int rst_at);
    int k;
    int cyc;
    bit rdy;
    k = 0;
    cyc = 0;
    while (k < NJET && cyc < 200) begin
      @(negedge clk);
      check("drain_valid", out_valid, 1);
      check("drain_jet", out_jet, exp_arr[k]);
      check("drain_last", out_last, (k == NJET - 1));
      check("drain_njets", n_jets, exp_n);
      check("drain_busy", busy, 1);
      if (mode == 0) rdy = 1'b1;
      else if (mode == 1) rdy = (cyc % 3 == 0);
      else rdy = 1'($urandom);
      out_ready = rdy;
      event_done = (mode == 2) ? 1'($urandom) : 1'b0;
      if (cyc == drop_at) begin
        jet_in = mk($urandom_range(0, 511), 7);
        jet_in_valid = 1'b1;
        exp_dropped = 1'b1;
      end
      if (cyc == rst_at) begin
        #2 reset = 1'b1;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_busy", busy, 0);
        check("arst_njets", n_jets, 0);
        check("arst_last", out_last, 0);
        check("arst_jet", out_jet, 0);
        #1 reset = 1'b0;
        out_ready = 1'b0;
        event_done = 1'b0;
        jet_in_valid = 1'b0;
        exp_dropped = 1'b0;
        mdl_q.delete();
        return;
      end
      @(posedge clk);
      if (rdy) k++;
      cyc++;
      #1 jet_in_valid = 1'b0;
      event_done = 1'b0;
    end
    if (k < NJET) check("drain_timeout", 0, 1);
    out_ready = 1'b0;
    @(negedge clk);
    check("post_valid", out_valid, 0);
    check("post_busy", busy, 0);
    check("post_njets", n_jets, 0);
    check("post_last", out_last, 0);
    check("post_dropped", dropped, exp_dropped);
    mdl_q.delete();
  endtask

  initial begin
    reset = 1'b1;
    jet_in = '0;
    jet_in_valid = 1'b0;
    event_done = 1'b0;
    out_ready = 1'b0;
    #12;
    check("rst_valid", out_valid, 0);
    check("rst_jet", out_jet, 0);
    check("rst_last", out_last, 0);
    check("rst_njets", n_jets, 0);
    check("rst_busy", busy, 0);
    check("rst_dropped", dropped, 0);
    @(negedge clk);
    reset = 1'b0;

    // Three jets, one empty trailing slot.
    send(mk(10, 1)); send(mk(50, 5)); send(mk(30, 9));
    end_event(0, 0, '0);
    drain(0, -1, -1);

    // Ties keep arrival order; lowest two are lost.
    send(mk(5, 0)); send(mk(40, 1)); send(mk(40, 2));
    send(mk(7, 3)); send(mk(90, 4)); send(mk(1, 5));
    end_event(0, 0, '0);
    drain(0, -1, -1);

    // Only jet arrives in the FLUSH cycle.
    end_event(0, 1, mk(20, 6));
    drain(0, -1, -1);

    // Stalled drain.
    send(mk(100, 1)); send(mk(200, 2)); send(mk(150, 3)); send(mk(300, 4)); send(mk(250, 5));
    end_event(0, 0, '0);
    drain(1, -1, -1);

    // Jet arriving during DRAIN is dropped.
    send(mk(60, 1)); send(mk(61, 2));
    end_event(0, 0, '0);
    drain(0, 1, -1);

    // Empty event.
    end_event(0, 0, '0);
    drain(0, -1, -1);

    // Async reset mid-drain, then a fresh event.
    send(mk(70, 1)); send(mk(80, 2));
    end_event(0, 0, '0);
    drain(0, -1, 1);
    @(negedge clk);
    check("arst_dropped", dropped, 0);
    send(mk(3, 2));
    end_event(0, 0, '0);
    drain(0, -1, -1);

    // Random events: ties, pt 0, n_jets saturation, co-incident and trailing jets.
    for (int e = 0; e < 8; e++) begin
      int cnt;
      cnt = (e == 0) ? 40 : $urandom_range(0, 36);
      for (int j = 0; j < cnt; j++) begin
        if (e % 2 == 0) send(mk($urandom_range(0, 15), j));
        else send(mk($urandom_range(0, 511), j));
      end
      end_event(1'($urandom), 1'($urandom), mk($urandom_range(0, 511), 30));
      drain(2, -1, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
